debounce_bank: RTL and testbench

//   N-channel input conditioner replacing per-signal debounce instances plus hand-written

---
 rtl/debounce_bank.sv | 177 +++++++++++++++++
 tb/tb_debounce_bank.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: N-channel input conditioner for raw board pins.
// Each channel is synchronised, debounced by a run-length counter and turned
// into a clean level plus one-cycle rise/fall pulses. any_rise is the OR of
// the rise vector and is registered in the same cycle as rise.
//
// Optional feature macro: DEBOUNCE_BANK_REPEAT_EN
//   When defined, a held-high channel emits extra rise pulses (key repeat):
//   first one REPEAT_DELAY cycles after the accepted rise, then every
//   REPEAT_PERIOD cycles until the clean level drops or reset is applied.
//   When undefined, rise pulses only on accepted 0->1 transitions.
module debounce_bank #(
  parameter int                  CHANNELS        = 8,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 650000,
  parameter int                  CNT_W           = 20,
  parameter logic [CHANNELS-1:0] RESET_VAL       = '0,
  parameter int                  REPEAT_DELAY    = 32500000,
  parameter int                  REPEAT_PERIOD   = 6500000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_rise
);

  // Last counter value before a change is accepted: a disagreeing sample
  // seen while the counter holds this value is the DEBOUNCE_CYCLES-th one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity checks on the configuration.
  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || CNT_W < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("debounce_bank: illegal parameter value");
  end
  if (((64'(DEBOUNCE_CYCLES) - 64'd1) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
    $error("debounce_bank: CNT_W too narrow for DEBOUNCE_CYCLES-1");
  end

  // ---------------------------------------------------------------------
  // Synchroniser chain
  // ---------------------------------------------------------------------
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_s;

  // Shift raw pins through SYNC_STAGES flops; reset loads the idle level so
  // that reset release never looks like an input change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= noisy;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Debounce counters and clean level
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] clean_q, clean_d;
  logic [CHANNELS-1:0] edge_rise, edge_fall;

  // Count consecutive samples that disagree with the clean level; any
  // agreeing sample restarts the run, so short glitches are discarded.
  // The counter never passes CNT_LAST: reaching it accepts the change.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign edge_rise = clean_d & ~clean_q;
  assign edge_fall = clean_q & ~clean_d;

  // ---------------------------------------------------------------------
  // Optional key-repeat generator
  // ---------------------------------------------------------------------
  logic [CHANNELS-1:0] rise_d;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic [REP_W-1:0]    rep_q [CHANNELS];
  logic [REP_W-1:0]    rep_d [CHANNELS];
  logic [CHANNELS-1:0] rep_pulse;

  // Down-counter per channel: loaded on the accepted rise, pulses when it
  // hits zero while the level stays high, then reloads with the period.
  // A falling or low level parks it at zero with no pulse.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      rep_d[i]     = '0;
      rep_pulse[i] = 1'b0;
      if (edge_rise[i]) begin
        rep_d[i] = REP_W'(REPEAT_DELAY - 1);
      end else if (clean_q[i] && clean_d[i]) begin
        if (rep_q[i] == '0) begin
          rep_pulse[i] = 1'b1;
          rep_d[i]     = REP_W'(REPEAT_PERIOD - 1);
        end else begin
          rep_d[i] = rep_q[i] - REP_W'(1);
        end
      end
    end
  end

  // Repeat counter state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rep_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        rep_q[i] <= rep_d[i];
      end
    end
  end

  assign rise_d = edge_rise | rep_pulse;
`else
  assign rise_d = edge_rise;
`endif

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic [CHANNELS-1:0] rise_q, fall_q;
  logic                any_rise_q;

  // Counter, level and pulse registers; pulses are registered alongside the
  // level so they coincide with the first cycle clean shows the new value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      clean_q    <= RESET_VAL;
      rise_q     <= '0;
      fall_q     <= '0;
      any_rise_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q    <= clean_d;
      rise_q     <= rise_d;
      fall_q     <= edge_fall;
      any_rise_q <= |rise_d;
    end
  end

  assign clean    = clean_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign any_rise = any_rise_q;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: self-checking bench for debounce_bank with CHANNELS=4,
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4. Directed scenarios, a vector table and
// a randomized run against a window-based reference model. A second
// instance with RESET_VAL=4'hF must never pulse. The repeat scenario runs
// on a third instance when DEBOUNCE_BANK_REPEAT_EN is defined.
module tb_debounce_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int CW = 3;
  localparam int RD = 200;
  localparam int RP = 13;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [CH-1:0] noisy, clean, rise, fall;
  logic          any_rise;
  logic [CH-1:0] noisy_b, clean_b, rise_b, fall_b;
  logic          any_rise_b;

  debounce_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW),
    .RESET_VAL(4'h0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .noisy(noisy),
    .clean(clean), .rise(rise), .fall(fall), .any_rise(any_rise)
  );

  debounce_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW),
    .RESET_VAL(4'hF), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .noisy(noisy_b),
    .clean(clean_b), .rise(rise_b), .fall(fall_b), .any_rise(any_rise_b)
  );

`ifdef DEBOUNCE_BANK_REPEAT_EN
  logic [CH-1:0] noisy_r, clean_r, rise_r, fall_r;
  logic          any_rise_r;

  debounce_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW),
    .RESET_VAL(4'h0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_r (
    .clock(clock), .reset_n(reset_n), .noisy(noisy_r),
    .clean(clean_r), .rise(rise_r), .fall(fall_r), .any_rise(any_rise_r)
  );
`endif

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The synchronised value seen by the debouncer is the pin value from SS
  // edges earlier; a channel flips once the last DC such samples all differ
  // from its clean level. Repeats follow from the age of the high level.
  logic [CH-1:0] m_dly[$];
  logic [CH-1:0] m_win[$];
  logic [CH-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
  int            m_age[CH];

  always @(posedge clock or negedge reset_n) begin : ref_model
    logic [CH-1:0] s, old, flip;
    if (!reset_n) begin
      m_dly = {};
      for (int k = 0; k < SS; k++) m_dly.push_back('0);
      m_win   = {};
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < CH; i++) m_age[i] = 0;
    end else begin
      m_dly.push_back(noisy);
      s = m_dly.pop_front();
      m_win.push_back(s);
      if (m_win.size() > DC) void'(m_win.pop_front());
      old  = m_clean;
      flip = '0;
      if (m_win.size() == DC) begin
        for (int i = 0; i < CH; i++) begin
          flip[i] = 1'b1;
          foreach (m_win[k]) if (m_win[k][i] == old[i]) flip[i] = 1'b0;
        end
      end
      m_clean = old ^ flip;
      m_rise  = m_clean & ~old;
      m_fall  = old & ~m_clean;
      for (int i = 0; i < CH; i++) begin
        if (m_rise[i]) m_age[i] = 0;
        else if (m_clean[i]) begin
          m_age[i]++;
`ifdef DEBOUNCE_BANK_REPEAT_EN
          if (m_age[i] >= RD && ((m_age[i] - RD) % RP) == 0) m_rise[i] = 1'b1;
`endif
        end
      end
    end
  end

  logic model_en = 1'b0;

  // Compare against the model on every falling edge while enabled.
  always @(negedge clock) begin
    if (model_en) begin
      check("rnd_clean", clean, m_clean);
      check("rnd_rise", rise, m_rise);
      check("rnd_fall", fall, m_fall);
      check("rnd_any_rise", any_rise, |m_rise);
    end
  end

  // Any pulse from the RESET_VAL=4'hF instance is an error (checked at end).
  int b_pulses = 0;
  always @(negedge clock) begin
    b_pulses += $countones(rise_b) + $countones(fall_b) + int'(any_rise_b);
  end

  // ---------------- driver tasks ----------------
  logic [CH-1:0] r_hist[32], f_hist[32];
  logic          a_hist[32];
  int            r_tot, f_tot, a_tot;
  logic [CH-1:0] r_or, f_or;

  task automatic clear_acc();
    r_tot = 0; f_tot = 0; a_tot = 0; r_or = '0; f_or = '0;
    for (int k = 0; k < 32; k++) begin
      r_hist[k] = '0; f_hist[k] = '0; a_hist[k] = 1'b0;
    end
  endtask

  // Sample outputs on the next n falling edges; index k follows rising edge k.
  task automatic watch(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      r_hist[k] = rise; f_hist[k] = fall; a_hist[k] = any_rise;
      r_tot += $countones(rise);
      f_tot += $countones(fall);
      a_tot += int'(any_rise);
      r_or |= rise;
      f_or |= fall;
    end
  endtask

  // Reset for two cycles, released right after a falling edge.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [CH-1:0] nz;
    int            hold;
    logic [CH-1:0] exp_clean;
    logic [CH-1:0] exp_rise;
    logic [CH-1:0] exp_fall;
  } vec_t;

  vec_t tbl[9];

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{4'h0, 8, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{4'h5, 8, 4'h5, 4'h5, 4'h0};
    tbl[2] = '{4'hF, 3, 4'h5, 4'h0, 4'h0};  // 3-cycle glitch on bits 1,3
    tbl[3] = '{4'h5, 8, 4'h5, 4'h0, 4'h0};
    tbl[4] = '{4'hA, 8, 4'hA, 4'hA, 4'h5};
    tbl[5] = '{4'h0, 8, 4'h0, 4'h0, 4'hA};
    tbl[6] = '{4'h3, 5, 4'h0, 4'h0, 4'h0};  // one cycle short of latency
    tbl[7] = '{4'h3, 4, 4'h3, 4'h3, 4'h0};  // accepted on first cycle here
    tbl[8] = '{4'h0, 8, 4'h0, 4'h0, 4'h3};

    noisy   = 4'hF;
    noisy_b = 4'hF;
`ifdef DEBOUNCE_BANK_REPEAT_EN
    noisy_r = 4'h0;
`endif

    // Scenario 1: reset with inputs high, then release.
    repeat (3) @(negedge clock);
    check("rst_clean", clean, 4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_any_rise", any_rise, 1'b0);
    check("rst_clean_b", clean_b, 4'hF);
    reset_n = 1'b1;
    clear_acc();
    watch(10);
    check("s1_rise_at6", r_hist[6], 4'hF);
    check("s1_any_at6", a_hist[6], 1'b1);
    check("s1_rise_total", r_tot, 4);
    check("s1_any_total", a_tot, 1);
    check("s1_fall_total", f_tot, 0);
    check("s1_clean", clean, 4'hF);

    // Scenario 2: single channel rise then fall, latency 6.
    noisy = 4'h0;
    do_reset();
    clear_acc(); watch(8);
    noisy[0] = 1'b1;
    clear_acc(); watch(10);
    check("s2_rise_at6", r_hist[6], 4'h1);
    check("s2_rise_total", r_tot, 1);
    check("s2_fall_total", f_tot, 0);
    check("s2_clean", clean, 4'h1);
    noisy[0] = 1'b0;
    clear_acc(); watch(10);
    check("s2_fall_at6", f_hist[6], 4'h1);
    check("s2_fall_total2", f_tot, 1);
    check("s2_rise_total2", r_tot, 0);

    // Scenario 3: 3-cycle pulse on channel 1 is rejected.
    clear_acc();
    noisy[1] = 1'b1; watch(3);
    noisy[1] = 1'b0; watch(10);
    check("s3_rise_total", r_tot, 0);
    check("s3_fall_total", f_tot, 0);
    check("s3_clean", clean, 4'h0);

    // Scenario 4: channel 2 chatters, settles high.
    clear_acc();
    for (int k = 0; k < 6; k++) begin
      noisy[2] = ~noisy[2];
      watch(1);
    end
    check("s4_chatter_pulses", r_tot + f_tot, 0);
    noisy[2] = ~noisy[2];
    clear_acc(); watch(10);
    check("s4_rise_at6", r_hist[6], 4'h4);
    check("s4_rise_total", r_tot, 1);
    check("s4_fall_total", f_tot, 0);

    // Scenario 5: reset mid-count, then reset while clean is high.
    noisy = 4'h0;
    do_reset();
    clear_acc(); watch(8);
    noisy[0] = 1'b1;
    clear_acc(); watch(3);
    #2 reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    clear_acc(); watch(10);
    check("s5a_rise_at6", r_hist[6], 4'h1);
    check("s5a_rise_total", r_tot, 1);
    check("s5a_fall_total", f_tot, 0);
    #2 reset_n = 1'b0;
    #1;
    check("s5b_async_clean", clean, 4'h0);
    check("s5b_async_rise", rise, 4'h0);
    check("s5b_async_fall", fall, 4'h0);
    @(negedge clock) reset_n = 1'b1;
    clear_acc(); watch(10);
    check("s5b_rise_at6", r_hist[6], 4'h1);
    check("s5b_fall_total", f_tot, 0);

    // Vector table.
    noisy = 4'h0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      noisy = tbl[i].nz;
      clear_acc();
      watch(tbl[i].hold);
      check($sformatf("tbl%0d_clean", i), clean, tbl[i].exp_clean);
      check($sformatf("tbl%0d_rise", i), r_or, tbl[i].exp_rise);
      check($sformatf("tbl%0d_fall", i), f_or, tbl[i].exp_fall);
    end

    // Randomized run against the reference model.
    begin
      int hold[CH];
      noisy = 4'h0;
      do_reset();
      model_en = 1'b1;
      for (int i = 0; i < CH; i++) hold[i] = 0;
      for (int n = 0; n < 4000; n++) begin
        @(negedge clock);
        for (int i = 0; i < CH; i++) begin
          if (hold[i] == 0) begin
            int sel;
            noisy[i] = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 4)      hold[i] = $urandom_range(0, 2);
            else if (sel < 9) hold[i] = $urandom_range(3, 11);
            else              hold[i] = $urandom_range(40, 300);
          end else begin
            hold[i]--;
          end
        end
        if (n == 2000) begin
          #2 reset_n = 1'b0;
          @(negedge clock) reset_n = 1'b1;
        end
      end
      model_en = 1'b0;
    end

`ifdef DEBOUNCE_BANK_REPEAT_EN
    // Repeat scenario: channel 3 held high, released at cycle 28.
    begin
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      int         fall_cnt, fall_at;
      exp_q = {8'd6, 8'd16, 8'd21, 8'd26, 8'd31};
      noisy_r = 4'h0;
      do_reset();
      noisy_r = 4'h8;
      fall_cnt = 0; fall_at = 0;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clock);
        if (rise_r[3]) got_q.push_back(8'(k));
        if (fall_r[3]) begin fall_cnt++; fall_at = k; end
        if (k == 28) noisy_r = 4'h0;
      end
      check("rep_count", got_q.size(), exp_q.size());
      foreach (exp_q[j]) begin
        if (j < got_q.size()) check($sformatf("rep_at_%0d", j), got_q[j], exp_q[j]);
      end
      check("rep_fall_count", fall_cnt, 1);
      check("rep_fall_at", fall_at, 34);
    end
`endif

    check("b_no_pulses", b_pulses, 0);
    check("b_clean", clean_b, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run is far shorter than this bound.
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
